// File: rtl/user_ip_apb_guard_if.sv
// rtl/user_ip_apb_guard_if.sv - APB4 bus bundle used on both sides of the guard
interface user_ip_apb_guard_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [2:0]              pprot;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   // Requester side: drives the request, receives the response
   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   // Completer side: receives the request, drives the response
   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/user_ip_apb_guard.sv
// rtl/user_ip_apb_guard.sv - APB4 pass-through with stall timeout and idle-only IP select update
`ifndef USER_IPSEL_WIDTH
`define USER_IPSEL_WIDTH 2
`endif

module user_ip_apb_guard #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    SEL_WIDTH   = `USER_IPSEL_WIDTH,
   parameter int                    TIMEOUT_CYC = 256,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   user_ip_apb_guard_if.slave   s,
   user_ip_apb_guard_if.master  m,
   input  logic [SEL_WIDTH-1:0] sel_req_i,
   output logic [SEL_WIDTH-1:0] sel_o,
   output logic                 sel_busy_o,
   output logic                 tmo_irq_o,
   output logic [15:0]          tmo_cnt_o,
   input  logic                 tmo_clr_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ABORT
   } state_t;

   // Last wait-counter value still allowed in ACCESS before the transfer is killed
   localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYC - 1);

   state_t                 state_q, state_d;
   logic [15:0]            wait_q, wait_d;
   logic [15:0]            tmo_cnt;
   logic [SEL_WIDTH-1:0]   sel_q;
   logic                   abort;

   assign abort = (state_q == ST_ABORT);

   // State and wait counter registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         wait_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next state: the first ACCESS cycle is seen in IDLE, so the counter enters ACCESS at 1
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_IDLE: begin
            wait_d = 16'd0;
            if (s.psel && s.penable && !m.pready) begin
               state_d = ST_ACCESS;
               wait_d  = 16'd1;
            end
         end
         ST_ACCESS: begin
            if (m.pready || !s.psel) begin
               // normal completion wins over a simultaneous limit hit
               state_d = ST_IDLE;
               wait_d  = 16'd0;
            end else if (wait_q == WAIT_LIMIT) begin
               state_d = ST_ABORT;
               wait_d  = 16'd0;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         ST_ABORT: begin
            state_d = ST_IDLE;
            wait_d  = 16'd0;
         end
         default: begin
            state_d = ST_IDLE;
            wait_d  = 16'd0;
         end
      endcase
   end

   // Bus outputs: pass-through, forced quiet during reset, and overridden in the abort cycle
   always_comb begin
      m.paddr   = '0;
      m.pprot   = '0;
      m.psel    = 1'b0;
      m.penable = 1'b0;
      m.pwrite  = 1'b0;
      m.pwdata  = '0;
      m.pstrb   = '0;
      s.pready  = 1'b0;
      s.prdata  = '0;
      s.pslverr = 1'b0;
      if (rst_n_i) begin
         m.paddr   = s.paddr;
         m.pprot   = s.pprot;
         m.pwrite  = s.pwrite;
         m.pwdata  = s.pwdata;
         m.pstrb   = s.pstrb;
         m.psel    = s.psel & ~abort;
         m.penable = s.penable & ~abort;
         s.pready  = abort | m.pready;
         s.prdata  = abort ? ERR_DATA : m.prdata;
         s.pslverr = abort | m.pslverr;
      end
   end

   // Saturating abort counter; software clear has priority
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt <= 16'd0;
      end else if (tmo_clr_i) begin
         tmo_cnt <= 16'd0;
      end else if (abort && (tmo_cnt != 16'hFFFF)) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   // IP select follows the request only when no transfer is open, so the mux never switches mid-transfer
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sel_q <= '0;
      end else if ((state_q == ST_IDLE) && !s.psel) begin
         sel_q <= sel_req_i;
      end
   end

   assign sel_o      = sel_q;
   assign sel_busy_o = (sel_req_i != sel_q);
   assign tmo_irq_o  = abort;
   assign tmo_cnt_o  = tmo_cnt;

endmodule

// File: tb/tb_user_ip_apb_guard.sv
// tb/tb_user_ip_apb_guard.sv - directed scoreboard bench for user_ip_apb_guard
module tb_user_ip_apb_guard;
   localparam int          TMO = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel_req = 2'd0;
   logic [1:0]  sel;
   logic        sel_busy;
   logic        tmo_irq;
   logic [15:0] tmo_cnt;
   logic        tmo_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_cnt = 16'd0;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   user_ip_apb_guard_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();
   user_ip_apb_guard_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_bus ();

   user_ip_apb_guard #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(2), .TIMEOUT_CYC(TMO), .ERR_DATA(ERR)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .s(s_bus.slave), .m(m_bus.master),
      .sel_req_i(sel_req), .sel_o(sel), .sel_busy_o(sel_busy),
      .tmo_irq_o(tmo_irq), .tmo_cnt_o(tmo_cnt), .tmo_clr_i(tmo_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One APB transfer; the bench also plays the downstream IP, holding pready low for 'waits' cycles
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] rd,
                       input int waits, input logic sel_chg, input logic clr);
      exp_t e;
      exp_t got;
      int   k;
      logic done;
      logic ab;
      ab      = (waits >= TMO);
      e.lat   = ab ? TMO + 1 : waits + 1;
      e.rdata = ab ? ERR : rd;
      e.err   = ab;
      sb.push_back(e);
      @(negedge clk);
      s_bus.psel = 1'b1; s_bus.penable = 1'b0; s_bus.pwrite = wr;
      s_bus.paddr = addr; s_bus.pwdata = ~addr; s_bus.pstrb = 4'hF; s_bus.pprot = 3'b010;
      m_bus.pready = 1'b0; m_bus.prdata = rd; m_bus.pslverr = 1'b0; tmo_clr = clr;
      #1;
      chk("setup_m_psel", {63'd0, m_bus.psel}, 64'd1);
      chk("setup_m_paddr", {32'd0, m_bus.paddr}, {32'd0, addr});
      @(negedge clk);
      s_bus.penable = 1'b1;
      k = 1;
      m_bus.pready = (k > waits);
      if (sel_chg) sel_req = 2'd1;
      done = 1'b0;
      while (!done && k < 20) begin
         #1;
         if (s_bus.pready) begin
            done = 1'b1;
         end else begin
            if (sel_chg) chk("sel_hold_wait", {62'd0, sel}, 64'd0);
            @(negedge clk);
            k++;
            m_bus.pready = (k > waits);
         end
      end
      got.lat = k; got.rdata = s_bus.prdata; got.err = s_bus.pslverr;
      e = sb.pop_front();
      chk("resp_seen", {63'd0, done}, 64'd1);
      chk("resp_latency", 64'(got.lat), 64'(e.lat));
      chk("resp_prdata", {32'd0, got.rdata}, {32'd0, e.rdata});
      chk("resp_pslverr", {63'd0, got.err}, {63'd0, e.err});
      chk("resp_m_psel", {63'd0, m_bus.psel}, {63'd0, ~ab});
      chk("resp_irq", {63'd0, tmo_irq}, {63'd0, ab});
      if (sel_chg) chk("sel_hold_done", {62'd0, sel}, 64'd0);
      if (clr) exp_cnt = 16'd0;
      else if (ab && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      s_bus.psel = 1'b0; s_bus.penable = 1'b0; m_bus.pready = 1'b0; tmo_clr = 1'b0;
      #1;
      chk("irq_single", {63'd0, tmo_irq}, 64'd0);
      if (sel_chg) begin
         chk("sel_gap_old", {62'd0, sel}, 64'd0);
         chk("sel_gap_busy", {63'd0, sel_busy}, 64'd1);
      end
      @(negedge clk);
      #1;
      chk("tmo_cnt", {48'd0, tmo_cnt}, {48'd0, exp_cnt});
      if (sel_chg) begin
         chk("sel_new", {62'd0, sel}, 64'd1);
         chk("sel_busy_clr", {63'd0, sel_busy}, 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      s_bus.psel = 1'b0; s_bus.penable = 1'b0; s_bus.pwrite = 1'b0;
      s_bus.paddr = 32'h5555_0000; s_bus.pwdata = '0; s_bus.pstrb = '0; s_bus.pprot = '0;
      m_bus.pready = 1'b1; m_bus.prdata = 32'hA5A5_A5A5; m_bus.pslverr = 1'b1;
      #23;
      // reset state: downstream response must not leak upstream while in reset
      chk("rst_s_pready", {63'd0, s_bus.pready}, 64'd0);
      chk("rst_s_prdata", {32'd0, s_bus.prdata}, 64'd0);
      chk("rst_s_pslverr", {63'd0, s_bus.pslverr}, 64'd0);
      chk("rst_m_paddr", {32'd0, m_bus.paddr}, 64'd0);
      chk("rst_cnt", {48'd0, tmo_cnt}, 64'd0);
      chk("rst_irq", {63'd0, tmo_irq}, 64'd0);
      m_bus.pready = 1'b0; m_bus.pslverr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // zero-wait read
      xfer(1'b0, 32'h0000_0010, 32'h1234_5678, 0, 1'b0, 1'b0);
      // write held off forever: abort
      xfer(1'b1, 32'h0000_0020, 32'h0BAD_0BAD, 99, 1'b0, 1'b0);
      // ready on the last allowed cycle: normal completion
      xfer(1'b0, 32'h0000_0030, 32'hCAFE_F00D, TMO - 1, 1'b0, 1'b0);
      // select request changes during a 3-wait read
      xfer(1'b0, 32'h0000_0040, 32'h1111_2222, 3, 1'b1, 1'b0);
      // saturation: preload near the top
      @(negedge clk);
      force dut.tmo_cnt = 16'hFFFE;
      #1;
      release dut.tmo_cnt;
      exp_cnt = 16'hFFFE;
      xfer(1'b0, 32'h0000_0050, 32'h0, 50, 1'b0, 1'b0);
      xfer(1'b1, 32'h0000_0054, 32'h0, 50, 1'b0, 1'b0);
      xfer(1'b0, 32'h0000_0058, 32'h0, 50, 1'b0, 1'b1);
      xfer(1'b1, 32'h0000_005C, 32'h0, 50, 1'b0, 1'b0);
      // reset in the middle of a stalled transfer
      @(negedge clk);
      s_bus.psel = 1'b1; s_bus.penable = 1'b0; s_bus.paddr = 32'h0000_0060;
      m_bus.pready = 1'b0; m_bus.prdata = 32'h7777_7777;
      sel_req = 2'd2;
      @(negedge clk);
      s_bus.penable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_m_psel", {63'd0, m_bus.psel}, 64'd0);
      chk("arst_m_paddr", {32'd0, m_bus.paddr}, 64'd0);
      chk("arst_s_prdata", {32'd0, s_bus.prdata}, 64'd0);
      chk("arst_sel", {62'd0, sel}, 64'd0);
      chk("arst_cnt", {48'd0, tmo_cnt}, 64'd0);
      exp_cnt = 16'd0;
      s_bus.psel = 1'b0; s_bus.penable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_sel", {62'd0, sel}, 64'd2);
      sel_req = 2'd0;
      @(negedge clk);
      xfer(1'b0, 32'h0000_0070, 32'h8888_9999, 1, 1'b0, 1'b0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
